// File: rtl/mmm_mod_add_pkg.sv
// Shared constants for the Montgomery modular add/subtract pipeline.
package mmm_mod_add_pkg;

  localparam int   WIDTH_DEFAULT = 260;
  localparam logic MODE_ADD      = 1'b0;
  localparam logic MODE_SUB      = 1'b1;

endpackage

// File: rtl/mmm_mod_add_if.sv
// Operation/result bundle of the modular adder; the requester is master, the adder is slave.
interface mmm_mod_add_if
  import mmm_mod_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             i_en_addsub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_mode;
  logic [WIDTH-1:0] i_p;
  logic [WIDTH-1:0] o_c;
  logic             o_flag;

  modport master (
    output i_en_addsub, i_a, i_b, i_mode, i_p,
    input  o_c, o_flag
  );

  modport slave (
    input  i_en_addsub, i_a, i_b, i_mode, i_p,
    output o_c, o_flag
  );

endinterface

// File: rtl/mmm_addsub_core.sv
// Combinational N-bit add/subtract; o_co is the carry on add and the borrow on subtract.
module mmm_addsub_core #(
  parameter int N = 261
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  input  logic         i_sub,
  output logic [N-1:0] o_sum,
  output logic         o_co
);

  logic [N:0] wide;

  always_comb begin
    wide = '0;
    if (i_sub) wide = {1'b0, i_x} - {1'b0, i_y};
    else       wide = {1'b0, i_x} + {1'b0, i_y};
  end

  assign {o_co, o_sum} = wide;

endmodule

// File: rtl/mmm_mod_add.sv
// Two-stage modular add/subtract: stage 1 registers the raw sum/difference,
// stage 2 applies a single conditional correction by p.
module mmm_mod_add
  import mmm_mod_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic          i_clk,
  input logic          i_rstn,
  mmm_mod_add_if.slave bus
);

  logic [WIDTH-1:0] s1_sum;
  logic             s1_co;
  logic [WIDTH:0]   raw_q;
  logic [WIDTH-1:0] p_q;
  logic             mode_q;
  logic             v1_q;
  logic [WIDTH:0]   corr_sum;
  logic             corr_co;
  logic [WIDTH-1:0] c_next;
  logic [WIDTH-1:0] c_q;
  logic             flag_q;
  logic             unused_corr_msb;

  mmm_addsub_core #(.N(WIDTH)) u_raw (
    .i_x   (bus.i_a),
    .i_y   (bus.i_b),
    .i_sub (bus.i_mode == MODE_SUB),
    .o_sum (s1_sum),
    .o_co  (s1_co)
  );

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      raw_q  <= '0;
      p_q    <= '0;
      mode_q <= MODE_ADD;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= bus.i_en_addsub;
      if (bus.i_en_addsub) begin
        raw_q  <= {s1_co, s1_sum};
        p_q    <= bus.i_p;
        mode_q <= bus.i_mode;
      end
    end
  end

  // Add mode tries raw - p (borrow means raw < p); subtract mode tries raw + p.
  mmm_addsub_core #(.N(WIDTH + 1)) u_corr (
    .i_x   (raw_q),
    .i_y   ({1'b0, p_q}),
    .i_sub (mode_q == MODE_ADD),
    .o_sum (corr_sum),
    .o_co  (corr_co)
  );

  assign unused_corr_msb = corr_sum[WIDTH];

  always_comb begin
    c_next = raw_q[WIDTH-1:0];
    if (mode_q == MODE_ADD) begin
      if (!corr_co) c_next = corr_sum[WIDTH-1:0];
    end else if (raw_q[WIDTH]) begin
      c_next = corr_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      c_q    <= '0;
      flag_q <= 1'b0;
    end else begin
      flag_q <= v1_q;
      if (v1_q) c_q <= c_next;
    end
  end

  assign bus.o_c    = c_q;
  assign bus.o_flag = flag_q;

endmodule

// File: tb/tb_mmm_mod_add.sv
// Self-checking bench for mmm_mod_add: directed boundary cases plus a randomized
// stream scored against a plain-arithmetic modular reference.
module tb_mmm_mod_add;
  import mmm_mod_add_pkg::*;

  localparam int W = 260;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mmm_mod_add_if #(.WIDTH(W)) bus ();

  mmm_mod_add #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rstn (rst),
    .bus    (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mode, input logic [W-1:0] p);
    bus.i_en_addsub = en;
    bus.i_a         = a;
    bus.i_b         = b;
    bus.i_mode      = mode;
    bus.i_p         = p;
  endtask

  // (a + b) mod p or (a - b) mod p with one correction, using plain wide arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic mode, input logic [W-1:0] p);
    logic [W+1:0] s;
    if (mode == MODE_ADD) begin
      s = {2'b00, a} + {2'b00, b};
      if (s >= {2'b00, p}) s = s - {2'b00, p};
    end else begin
      if (a >= b) s = {2'b00, a} - {2'b00, b};
      else        s = {2'b00, a} + {2'b00, p} - {2'b00, b};
    end
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[W-33:0], $urandom()};
    return r;
  endfunction

  task automatic test_reset;
    drive(1'b0, '0, '0, MODE_ADD, 260'd97);
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.o_c !== '0) begin n_fail++; $display("FAIL reset_c got %0h exp 0", bus.o_c); end
    n_checks++;
    if (bus.o_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b exp 0", bus.o_flag); end
    step;
    step;
    #2 rst = 1'b0;
    drive(1'b1, 260'd60, 260'd50, MODE_ADD, 260'd97);
    step;
    drive(1'b1, 260'd5, 260'd7, MODE_SUB, 260'd97);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b1 || bus.o_c !== 260'd13) begin
      n_fail++; $display("FAIL pre_reset_op got flag=%b c=%0d exp flag=1 c=13", bus.o_flag, bus.o_c);
    end
    // Assert reset between edges while operations are in flight.
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_c !== '0 || bus.o_flag !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got flag=%b c=%0d exp flag=0 c=0", bus.o_flag, bus.o_c);
    end
    step;
    n_checks++;
    if (bus.o_c !== '0 || bus.o_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_held got flag=%b c=%0d exp flag=0 c=0", bus.o_flag, bus.o_c);
    end
    drive(1'b0, '0, '0, MODE_ADD, 260'd97);
    #2 rst = 1'b0;
    step;
    n_checks++;
    if (bus.o_flag !== 1'b0) begin n_fail++; $display("FAIL inflight_discard1 got flag=%b exp 0", bus.o_flag); end
    step;
    n_checks++;
    if (bus.o_flag !== 1'b0 || bus.o_c !== '0) begin
      n_fail++; $display("FAIL inflight_discard2 got flag=%b c=%0d exp flag=0 c=0", bus.o_flag, bus.o_c);
    end
    drive(1'b1, 260'd10, 260'd20, MODE_ADD, 260'd97);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b0) begin n_fail++; $display("FAIL first_edge_flag got %b exp 0", bus.o_flag); end
    drive(1'b0, '0, '0, MODE_ADD, 260'd97);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b1 || bus.o_c !== 260'd30) begin
      n_fail++; $display("FAIL first_result got flag=%b c=%0d exp flag=1 c=30", bus.o_flag, bus.o_c);
    end
    step;
  endtask

  task automatic test_wide_add;
    logic [W-1:0] p, a, b, exp_c;
    p = '0;
    p[259] = 1'b1;
    a = 260'h29c1685372e6fdccaee2c6161d828bbb9f768f903743d3ce2981d290fb3c9d9e;
    b = 260'hd2024aec878e7b574728e44ec83e2ec94fb5dac01879c806fc33a8744458caec;
    exp_c = 260'hfbc3b33ffa757923f60baa64e5c0ba84ef2c6a504fbd9bd525b57b053f95688a;
    drive(1'b1, a, b, MODE_ADD, p);
    step;
    drive(1'b0, '0, '0, MODE_ADD, p);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b1 || bus.o_c !== exp_c) begin
      n_fail++; $display("FAIL wide_add got flag=%b c=%h exp flag=1 c=%h", bus.o_flag, bus.o_c, exp_c);
    end
    step;
    n_checks++;
    if (bus.o_flag !== 1'b0 || bus.o_c !== exp_c) begin
      n_fail++; $display("FAIL wide_add_hold got flag=%b c=%h exp flag=0 c=%h", bus.o_flag, bus.o_c, exp_c);
    end
  endtask

  task automatic test_add_sub_p97;
    int a_t[6]   = '{60, 40, 96, 50, 60, 33};
    int b_t[6]   = '{50, 57, 96, 60, 50, 33};
    int m_t[6]   = '{0, 0, 0, 1, 1, 1};
    int exp_t[6] = '{13, 0, 95, 87, 10, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, W'(a_t[i]), W'(b_t[i]), m_t[i][0], 260'd97);
      step;
      drive(1'b0, '0, '0, MODE_ADD, 260'd97);
      step;
      n_checks++;
      if (bus.o_flag !== 1'b1 || bus.o_c !== W'(exp_t[i])) begin
        n_fail++;
        $display("FAIL p97_case%0d (%0d %s %0d) got flag=%b c=%0d exp flag=1 c=%0d", i, a_t[i],
                 m_t[i] != 0 ? "-" : "+", b_t[i], bus.o_flag, bus.o_c, exp_t[i]);
      end
      step;
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 260'd60, 260'd50, MODE_ADD, 260'd97);
    step;
    drive(1'b1, 260'd50, 260'd60, MODE_SUB, 260'd97);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b1 || bus.o_c !== 260'd13) begin
      n_fail++; $display("FAIL b2b_0 got flag=%b c=%0d exp flag=1 c=13", bus.o_flag, bus.o_c);
    end
    drive(1'b1, 260'd1, 260'd2, MODE_ADD, 260'd97);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b1 || bus.o_c !== 260'd87) begin
      n_fail++; $display("FAIL b2b_1 got flag=%b c=%0d exp flag=1 c=87", bus.o_flag, bus.o_c);
    end
    drive(1'b0, '0, '0, MODE_ADD, 260'd97);
    step;
    n_checks++;
    if (bus.o_flag !== 1'b1 || bus.o_c !== 260'd3) begin
      n_fail++; $display("FAIL b2b_2 got flag=%b c=%0d exp flag=1 c=3", bus.o_flag, bus.o_c);
    end
    step;
    n_checks++;
    if (bus.o_flag !== 1'b0 || bus.o_c !== 260'd3) begin
      n_fail++; $display("FAIL b2b_drain got flag=%b c=%0d exp flag=0 c=3", bus.o_flag, bus.o_c);
    end
  endtask

  task automatic test_enable_gaps;
    logic en_t[7]   = '{1, 0, 0, 0, 1, 0, 0};
    logic flag_t[7] = '{0, 1, 0, 0, 0, 1, 0};
    int   c_t[7]    = '{3, 30, 30, 30, 30, 93, 93};
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drive(1'b1, 260'd10, 260'd20, MODE_ADD, 260'd97);
      else if (i == 4) drive(1'b1, 260'd5, 260'd9, MODE_SUB, 260'd97);
      else             drive(en_t[i], 260'd1, 260'd1, MODE_ADD, 260'd97);
      step;
      n_checks++;
      if (bus.o_flag !== flag_t[i] || bus.o_c !== W'(c_t[i])) begin
        n_fail++;
        $display("FAIL gap_cycle%0d got flag=%b c=%0d exp flag=%b c=%0d", i, bus.o_flag, bus.o_c,
                 flag_t[i], c_t[i]);
      end
    end
  endtask

  task automatic test_random;
    logic         en, mode, pend_v, known;
    logic [W-1:0] a, b, p, exp_c, pend_c, last_c;
    pend_v = 1'b0;
    known  = 1'b0;
    pend_c = '0;
    last_c = '0;
    for (int i = 0; i < 300; i++) begin
      en = (i < 298) ? ($urandom_range(0, 9) < 7) : 1'b0;
      p  = rand_w() >> $urandom_range(0, 258);
      if (p == '0) p = 260'd1;
      a  = rand_w() % p;
      b  = rand_w() % p;
      if ($urandom_range(0, 15) == 0) begin
        a = p - 1;
        b = p - 1;
      end
      mode  = 1'($urandom_range(0, 1));
      exp_c = ref_model(a, b, mode, p);
      drive(en, a, b, mode, p);
      step;
      n_checks++;
      if (bus.o_flag !== pend_v) begin
        n_fail++; $display("FAIL rand_flag cycle%0d got %b exp %b", i, bus.o_flag, pend_v);
      end
      if (pend_v) begin
        last_c = pend_c;
        known  = 1'b1;
      end
      if (known) begin
        n_checks++;
        if (bus.o_c !== last_c) begin
          n_fail++; $display("FAIL rand_c cycle%0d got %h exp %h", i, bus.o_c, last_c);
        end
      end
      pend_v = en;
      pend_c = exp_c;
    end
  endtask

  initial begin
    drive(1'b0, '0, '0, MODE_ADD, 260'd97);
    test_reset;
    test_wide_add;
    test_add_sub_p97;
    test_back_to_back;
    test_enable_gaps;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmm_mod_add.md
Name: mmm_mod_add

Overview:
- Pipelined modular adder/subtractor for the Montgomery multiplier datapath.
- Computes (a + b) mod p or (a - b) mod p on WIDTH-bit unsigned operands, with one conditional correction by p.
- Fixed 2-cycle latency; accepts a new operation every cycle.
- Result and a valid flag come from registers.

Parameters:
- WIDTH, 260, operand/modulus/result width in bits.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  reset, asynchronous, active-high. The name is kept per codebase; asserted level is 1.
- i_en_addsub  input  1  operation enable; inputs are sampled on a rising edge when high.
- i_a  input  WIDTH  operand a, unsigned; must satisfy a < p.
- i_b  input  WIDTH  operand b, unsigned; must satisfy b < p.
- i_mode  input  1  0 = modular add, 1 = modular subtract.
- i_p  input  WIDTH  modulus, unsigned, 1 <= p < 2^WIDTH. Sampled per operation, so it may change every cycle.
- o_c  output  WIDTH  registered result.
- o_flag  output  1  registered result-valid strobe.

Behaviour:
- Reset (i_rstn=1, asynchronous) clears all pipeline registers: o_c=0, o_flag=0, stage-1 valid=0.
- Reset mid-operation discards every in-flight operation; none emerges after reset is released.
- Stage 1 (on edge with i_en_addsub=1) registers:
  - raw = a + b (mode 0) or a - b (mode 1), computed WIDTH+1 bits wide with the carry/borrow as the MSB;
  - p and mode;
  - v1 = 1.
- Stage 1 with i_en_addsub=0: v1 = 0; data registers may hold their values.
- Stage 2 computes:
  - Mode 0: t = raw - p (WIDTH+2-bit signed). If t >= 0 then o_c = t[WIDTH-1:0], else o_c = raw[WIDTH-1:0].
  - Mode 1: if borrow (a < b) then o_c = (raw + p)[WIDTH-1:0], else o_c = raw[WIDTH-1:0].
  - Stage 2 updates o_c only when v1=1; otherwise o_c holds its last value.
  - o_flag <= v1 every cycle.
- Latency: inputs sampled at edge N give o_c/o_flag valid after edge N+2.
- Throughput: 1 operation per cycle. Continuous enable gives o_flag continuously high from the 2nd edge onward.
- Operands >= p: the output is the single-correction value above; no further reduction is performed.
- Boundary results:
  - a + b == p gives 0.
  - a == b in subtract mode gives 0.
  - a = p-1, b = p-1 gives p-2.
- No internal state other than the two pipeline stages. Mode can switch every cycle.

Decomposition:
- Shared package: mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1; default WIDTH constant 260.
- One natural sub-module, mmm_addsub_core: a combinational WIDTH+1-bit add/subtract with carry/borrow out. It is instantiated for the stage-1 raw computation and again for the stage-2 correction (subtract p or add p).

Test Plan:
- Reset: assert i_rstn=1 mid-stream with i_en_addsub=1 -> o_c=0 and o_flag=0 immediately; after release, first o_flag=1 appears exactly 2 edges after the first sampled enable.
- Wide add, no wrap, WIDTH=260, p=2^259, mode=0:
  - a=0x29c1685372e6fdccaee2c6161d828bbb9f768f903743d3ce2981d290fb3c9d9e
  - b=0xd2024aec878e7b574728e44ec83e2ec94fb5dac01879c806fc33a8744458caec
  - -> o_c=0xfbc3b33ffa757923f60baa64e5c0ba84ef2c6a504fbd9bd525b57b053f95688a, o_flag=1 two cycles later.
- Add with wrap, p=97: (a=60,b=50) -> 13; (a=40,b=57) -> 0; (a=96,b=96) -> 95.
- Subtract, p=97: (a=50,b=60) -> 87; (a=60,b=50) -> 10; (a=33,b=33) -> 0.
- Back-to-back alternating modes, p=97, one op per cycle: add(60,50), sub(50,60), add(1,2) -> o_c sequence 13, 87, 3 on consecutive cycles with o_flag held high.
- Enable gaps: enable for 1 cycle, low for 3, then enable again -> o_flag is a 1-cycle pulse per operation, and o_c holds its value between pulses.
